cpu_ctrl: RTL and testbench
===========================

Name: cpu_ctrl

Overview:
- Multi-cycle control and sequencing unit for the simple 8-bit accumulator processor; sits directly upstream of the ALU.
- Fetches 8-bit instructions from a synchronous-read memory and decodes them.
- Drives the ALU's en/sel/in1/in2 and writes the ALU result back to the accumulator.
- Uses the ALU's alu_zero flag for the skip-if-zero instruction.

Parameters:
- PC_RESET, 0, value loaded into the 5-bit PC at reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- run  in  1  start request; sampled only in IDLE.
- mem_addr  out  5  memory address.
- mem_rdata  in  8  memory read data; valid the cycle after mem_addr is presented.
- mem_we  out  1  memory write strobe, one cycle.
- mem_wdata  out  8  memory write data.
- alu_en  out  1  ALU enable.
- alu_sel  out  3  ALU operation select.
- alu_in1  out  8  ALU operand 1.
- alu_in2  out  8  ALU operand 2.
- alu_out  in  8  ALU result; registered by the ALU on the alu_en cycle.
- alu_zero  in  1  ALU zero flag; registered by the ALU on the alu_en cycle.
- acc  out  8  accumulator.
- pc  out  5  program counter.
- halted  out  1  high while in HALT.
- busy  out  1  high in every state except IDLE and HALT.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset, including mid-instruction: state=IDLE, pc=PC_RESET, acc=0, ir=0, opnd=0.
  - Any in-flight instruction is abandoned; no write or writeback completes.
- Output decoding: outputs are Moore-decoded from registered state. Defaults are mem_we=0, alu_en=0, alu_sel=000, alu_in1=acc, alu_in2=opnd, mem_addr=pc, mem_wdata=acc.
- Instruction format: ir[7:5] is the opcode, ir[4:0] is the address a.
  - 000 HLT: halt.
  - 001 SKZ: skip next instruction if acc==0.
  - 010 ADD: acc=acc+M[a].
  - 011 SUB: acc=acc-M[a].
  - 100 SHL: acc=acc<<M[a].
  - 101 LDA: acc=M[a].
  - 110 STO: M[a]=acc.
  - 111 JMP: pc=a.
- States and transitions:
  - IDLE: go to FETCH when run=1.
  - FETCH: mem_addr=pc; go to IR.
  - IR: ir<=mem_rdata; pc<=pc+1 (mod 32, so 31 wraps to 0); go to DEC.
  - DEC: mem_addr=a.
    - HLT: go to HALT.
    - JMP: pc<=a; go to FETCH.
    - STO: mem_we=1, mem_wdata=acc; go to FETCH.
    - SKZ: go to EXEC.
    - Others: go to OPND.
  - OPND: opnd<=mem_rdata; go to EXEC.
  - EXEC: alu_en=1 for exactly one cycle; go to WB.
    - alu_sel: 000 for LDA, 001 for SKZ, 010 for ADD, 011 for SUB, 100 for SHL.
    - alu_in1 = opnd for LDA, otherwise acc. alu_in2 = opnd.
  - WB:
    - SKZ: if alu_zero=1 then pc<=pc+1 (mod 32); acc unchanged.
    - Other opcodes: acc<=alu_out.
    - Go to FETCH.
  - HALT: halted=1, busy=0; leave only via rst; run is ignored.
- Latency in cycles, FETCH to next FETCH:
  - ADD/SUB/SHL/LDA: 6.
  - SKZ: 5 (FETCH, IR, DEC, EXEC, WB).
  - STO/JMP: 3.
  - HLT: 3 cycles to reach HALT.
- Arithmetic and width rules:
  - acc is 8-bit, modulo 256; no carry or overflow flag.
  - SHL amounts of 8 or more yield 0, as computed by the ALU.
- mem_we is never asserted outside DEC of a STO.
- alu_en is never asserted outside EXEC.
- A JMP target of the current PC is legal and spins.
- A SKZ skip at pc=31 wraps to 0.
- run asserted during busy states has no effect.

Test Plan:
- Reset then run=1, memory M[0]=101_00100 (LDA 4), M[1]=010_00101 (ADD 5), M[2]=110_00110 (STO 6), M[3]=000_00000 (HLT), M[4]=0x1F, M[5]=0x03 -> M[6]=0x22, acc=0x22, halted=1, pc=4; first ALU use has alu_sel=000, alu_in1=0x1F.
- SUB underflow: acc=0x02, SUB with operand 0x05 -> acc=0xFD.
- SHL: acc=0x81, SHL with operand 0x01 -> acc=0x02.
- SKZ with acc=0 at pc=2 -> instruction at 3 skipped, next FETCH mem_addr=4.
- SKZ with acc=0x01 -> instruction at 3 executed.
- JMP wrap: instruction at pc=31 is 111_00000 -> next FETCH mem_addr=0; also SKZ at 30 with acc=0 -> next FETCH mem_addr=0.
- Cycle count: an ADD takes exactly 6 cycles FETCH-to-FETCH, with alu_en high exactly 1 cycle; a STO takes 3 cycles with mem_we high exactly 1 cycle.
- Reset mid-instruction: assert rst during EXEC of ADD -> immediately state=IDLE, acc=0, pc=PC_RESET, alu_en=0, mem_we=0; run=1 afterwards restarts from PC_RESET.

Source files
------------

// File: rtl/cpu_ctrl_if.sv
// Memory and ALU bus of the accumulator processor controller.
// The controller is the master: it drives addresses, strobes and ALU operands,
// and receives read data plus the registered ALU result and zero flag.
interface cpu_ctrl_if;
   logic [4:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       mem_we;
   logic [7:0] mem_wdata;
   logic       alu_en;
   logic [2:0] alu_sel;
   logic [7:0] alu_in1;
   logic [7:0] alu_in2;
   logic [7:0] alu_out;
   logic       alu_zero;

   modport master (
      output mem_addr, mem_we, mem_wdata, alu_en, alu_sel, alu_in1, alu_in2,
      input  mem_rdata, alu_out, alu_zero
   );

   modport slave (
      input  mem_addr, mem_we, mem_wdata, alu_en, alu_sel, alu_in1, alu_in2,
      output mem_rdata, alu_out, alu_zero
   );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Instructions are {opcode[2:0], address[4:0]}; memory reads have one cycle of
// latency, and the ALU registers its result/zero flag on the alu_en cycle, so
// writeback happens one state after EXEC.
module cpu_ctrl #(
   parameter logic [4:0] PC_RESET = 5'd0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   cpu_ctrl_if.master        bus,
   output logic [7:0]        acc,
   output logic [4:0]        pc,
   output logic              halted,
   output logic              busy
);

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_SHL = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_IR, S_DEC, S_OPND, S_EXEC, S_WB, S_HALT
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] ir;
   logic [7:0] opnd;
   logic [2:0] op;
   logic [4:0] addr;

   assign op   = ir[7:5];
   assign addr = ir[4:0];

   // State register; reset abandons any in-flight instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state sequencing; HALT is only left through reset.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (run) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_IR;
         S_IR:    state_nxt = S_DEC;
         S_DEC: begin
            case (op)
               OP_HLT:         state_nxt = S_HALT;
               OP_JMP, OP_STO: state_nxt = S_FETCH;
               OP_SKZ:         state_nxt = S_EXEC;
               default:        state_nxt = S_OPND;
            endcase
         end
         S_OPND:  state_nxt = S_EXEC;
         S_EXEC:  state_nxt = S_WB;
         S_WB:    state_nxt = S_FETCH;
         S_HALT:  state_nxt = S_HALT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Moore outputs decoded from the current state only.
   always_comb begin
      bus.mem_addr  = pc;
      bus.mem_we    = 1'b0;
      bus.mem_wdata = acc;
      bus.alu_en    = 1'b0;
      bus.alu_sel   = 3'b000;
      bus.alu_in1   = acc;
      bus.alu_in2   = opnd;
      halted        = (state == S_HALT);
      busy          = (state != S_IDLE) && (state != S_HALT);
      case (state)
         S_DEC: begin
            bus.mem_addr = addr;
            if (op == OP_STO) bus.mem_we = 1'b1;
         end
         S_EXEC: begin
            bus.alu_en = 1'b1;
            case (op)
               OP_SKZ:  bus.alu_sel = 3'b001;
               OP_ADD:  bus.alu_sel = 3'b010;
               OP_SUB:  bus.alu_sel = 3'b011;
               OP_SHL:  bus.alu_sel = 3'b100;
               default: bus.alu_sel = 3'b000;
            endcase
            // LDA routes the fetched operand through the ALU as a pass-through.
            if (op == OP_LDA) bus.alu_in1 = opnd;
         end
         default: ;
      endcase
   end

   // Architectural registers: instruction/operand capture, PC update, writeback.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc   <= PC_RESET;
         acc  <= 8'h00;
         ir   <= 8'h00;
         opnd <= 8'h00;
      end else begin
         case (state)
            S_IR: begin
               ir <= bus.mem_rdata;
               pc <= pc + 5'd1;
            end
            S_DEC:  if (op == OP_JMP) pc <= addr;
            S_OPND: opnd <= bus.mem_rdata;
            S_WB: begin
               if (op == OP_SKZ) begin
                  if (bus.alu_zero) pc <= pc + 5'd1;
               end else begin
                  acc <= bus.alu_out;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: behavioural synchronous memory and ALU around the
// controller, with a scoreboard of expected ALU operations and memory writes.
module tb_cpu_ctrl;

   localparam logic [4:0] PC_RST = 5'd0;
   localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, SUB = 3'b011;
   localparam logic [2:0] SHL = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

   typedef struct packed {
      logic       we;
      logic [4:0] a;
      logic [7:0] b;
      logic [7:0] c;
   } ev_t;

   logic       clk;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic       load = 1'b0;
   logic [7:0] acc;
   logic [4:0] pc;
   logic       halted;
   logic       busy;

   logic [7:0] mem      [32];
   logic [7:0] init_mem [32];
   ev_t        exp_q [$];
   ev_t        obs_q [$];
   int         obs_cyc [$];
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   cpu_ctrl_if bus ();

   cpu_ctrl #(.PC_RESET(PC_RST)) dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .bus    (bus),
      .acc    (acc),
      .pc     (pc),
      .halted (halted),
      .busy   (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read memory with one-cycle read latency.
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
      end else begin
         bus.mem_rdata <= mem[bus.mem_addr];
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [7:0] a,
                                         input logic [7:0] b);
      case (s)
         3'b010:  return a + b;
         3'b011:  return a - b;
         3'b100:  return (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
         default: return a;
      endcase
   endfunction

   // ALU registers its result and zero flag on the enable cycle.
   always @(posedge clk) begin
      if (bus.alu_en) begin
         bus.alu_out  <= alu_f(bus.alu_sel, bus.alu_in1, bus.alu_in2);
         bus.alu_zero <= (alu_f(bus.alu_sel, bus.alu_in1, bus.alu_in2) == 8'h00);
      end
   end

   // Monitor: record every ALU operation and memory write with its cycle.
   always @(negedge clk) begin
      if (bus.alu_en) begin
         obs_q.push_back({1'b0, {2'b00, bus.alu_sel}, bus.alu_in1, bus.alu_in2});
         obs_cyc.push_back(cyc);
      end
      if (bus.mem_we) begin
         obs_q.push_back({1'b1, bus.mem_addr, bus.mem_wdata, 8'h00});
         obs_cyc.push_back(cyc);
      end
   end

   function automatic logic [7:0] ins(input logic [2:0] o, input logic [4:0] a);
      return {o, a};
   endfunction

   function automatic void exp_alu(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
      exp_q.push_back({1'b0, {2'b00, s}, a, b});
   endfunction

   function automatic void exp_we(input logic [4:0] a, input logic [7:0] d);
      exp_q.push_back({1'b1, a, d, 8'h00});
   endfunction

   task automatic prep;
      for (int i = 0; i < 32; i++) init_mem[i] = 8'h00;
      exp_q.delete();
   endtask

   task automatic start_prog;
      rst  = 1'b1;
      run  = 1'b0;
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      @(posedge clk); #1;
      obs_q.delete();
      obs_cyc.delete();
      rst = 1'b0;
      run = 1'b1;
   endtask

   task automatic wait_halt(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(posedge clk); #1;
         if (halted) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #2;
      run = 1'b1;
      rst = 1'b1;
      #1;
      n_tests++; if (acc !== 8'h00) begin n_fail++; $display("FAIL reset_acc got %h want 00", acc); end
      n_tests++; if (pc !== PC_RST) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, PC_RST); end
      n_tests++; if (busy !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_status got busy=%b halted=%b want 0 0", busy, halted); end
      n_tests++; if (bus.alu_en !== 1'b0 || bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got alu_en=%b mem_we=%b want 0 0", bus.alu_en, bus.mem_we); end
      n_tests++; if (bus.mem_addr !== PC_RST) begin n_fail++; $display("FAIL reset_addr got %h want %h", bus.mem_addr, PC_RST); end
      @(posedge clk); #1;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold_busy got %b want 0", busy); end
   endtask

   task automatic test_program;
      bit ok;
      ev_t e, o;
      prep();
      init_mem[0] = ins(LDA, 5'd4);
      init_mem[1] = ins(ADD, 5'd5);
      init_mem[2] = ins(STO, 5'd6);
      init_mem[3] = ins(HLT, 5'd0);
      init_mem[4] = 8'h1F;
      init_mem[5] = 8'h03;
      exp_alu(3'b000, 8'h1F, 8'h1F);
      exp_alu(3'b010, 8'h1F, 8'h03);
      exp_we(5'd6, 8'h22);
      start_prog();
      wait_halt(300, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL prog_halt got halted=%b want 1", halted); end
      n_tests++; if (acc !== 8'h22) begin n_fail++; $display("FAIL prog_acc got %h want 22", acc); end
      n_tests++; if (pc !== 5'd4) begin n_fail++; $display("FAIL prog_pc got %0d want 4", pc); end
      n_tests++; if (mem[6] !== 8'h22) begin n_fail++; $display("FAIL prog_mem6 got %h want 22", mem[6]); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prog_busy got %b want 0", busy); end
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (halted !== 1'b1 || pc !== 5'd4) begin n_fail++; $display("FAIL prog_stay_halted got halted=%b pc=%0d want 1 4", halted, pc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL prog_event got none want %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL prog_event got %h want %h", o, e); end end
      end
      n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL prog_extra got %0d events want 0", obs_q.size()); end
   endtask

   task automatic test_arith(input string nm, input logic [2:0] opc, input logic [7:0] a0,
                             input logic [7:0] b0, input logic [7:0] want);
      bit ok;
      ev_t e, o;
      prep();
      init_mem[0]  = ins(LDA, 5'd10);
      init_mem[1]  = ins(opc, 5'd11);
      init_mem[2]  = ins(HLT, 5'd0);
      init_mem[10] = a0;
      init_mem[11] = b0;
      exp_alu(3'b000, a0, a0);
      exp_alu(opc, a0, b0);
      start_prog();
      wait_halt(300, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL %s_halt got halted=%b want 1", nm, halted); end
      n_tests++; if (acc !== want) begin n_fail++; $display("FAIL %s_acc got %h want %h", nm, acc, want); end
      n_tests++; if (pc !== 5'd3) begin n_fail++; $display("FAIL %s_pc got %0d want 3", nm, pc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s_event got none want %h", nm, e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL %s_event got %h want %h", nm, o, e); end end
      end
      n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL %s_extra got %0d events want 0", nm, obs_q.size()); end
   endtask

   // SKZ at pc=2; the instruction at 3 loads 0x55, the one at 4 halts.
   task automatic test_skz(input logic [7:0] v);
      bit ok;
      ev_t e, o;
      logic [7:0] want;
      prep();
      init_mem[0]  = ins(LDA, 5'd10);
      init_mem[1]  = ins(LDA, 5'd10);
      init_mem[2]  = ins(SKZ, 5'd0);
      init_mem[3]  = ins(LDA, 5'd11);
      init_mem[4]  = ins(HLT, 5'd0);
      init_mem[10] = v;
      init_mem[11] = 8'h55;
      exp_alu(3'b000, v, v);
      exp_alu(3'b000, v, v);
      exp_alu(3'b001, v, v);
      if (v != 8'h00) exp_alu(3'b000, 8'h55, 8'h55);
      want = (v == 8'h00) ? v : 8'h55;
      start_prog();
      wait_halt(300, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL skz%0h_halt got halted=%b want 1", v, halted); end
      n_tests++; if (acc !== want) begin n_fail++; $display("FAIL skz%0h_acc got %h want %h", v, acc, want); end
      n_tests++; if (pc !== 5'd5) begin n_fail++; $display("FAIL skz%0h_pc got %0d want 5", v, pc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL skz%0h_event got none want %h", v, e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL skz%0h_event got %h want %h", v, o, e); end end
      end
      n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL skz%0h_extra got %0d events want 0", v, obs_q.size()); end
   endtask

   // JMP 0 at address 31; the second pass through address 0 sees acc=1 and halts at 1.
   task automatic test_jmp_wrap;
      bit ok;
      ev_t e, o;
      prep();
      init_mem[0]  = ins(SKZ, 5'd0);
      init_mem[1]  = ins(HLT, 5'd0);
      init_mem[2]  = ins(LDA, 5'd20);
      init_mem[3]  = ins(JMP, 5'd31);
      init_mem[31] = ins(JMP, 5'd0);
      init_mem[20] = 8'h01;
      exp_alu(3'b001, 8'h00, 8'h00);
      exp_alu(3'b000, 8'h01, 8'h01);
      exp_alu(3'b001, 8'h01, 8'h01);
      start_prog();
      wait_halt(300, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL jmpwrap_halt got halted=%b want 1", halted); end
      n_tests++; if (pc !== 5'd2 || acc !== 8'h01) begin n_fail++; $display("FAIL jmpwrap_state got pc=%0d acc=%h want 2 01", pc, acc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL jmpwrap_event got none want %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL jmpwrap_event got %h want %h", o, e); end end
      end
      n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL jmpwrap_extra got %0d events want 0", obs_q.size()); end
   endtask

   // SKZ at 30 with acc=0 skips 31 and wraps to 0; a flag stored at M[21] ends the loop.
   task automatic test_skz_wrap;
      bit ok;
      ev_t e, o;
      prep();
      init_mem[0]  = ins(LDA, 5'd21);
      init_mem[1]  = ins(SKZ, 5'd0);
      init_mem[2]  = ins(HLT, 5'd0);
      init_mem[3]  = ins(ADD, 5'd22);
      init_mem[4]  = ins(STO, 5'd21);
      init_mem[5]  = ins(LDA, 5'd20);
      init_mem[6]  = ins(JMP, 5'd30);
      init_mem[7]  = ins(HLT, 5'd0);
      init_mem[22] = 8'h01;
      init_mem[30] = ins(SKZ, 5'd0);
      init_mem[31] = ins(JMP, 5'd7);
      exp_alu(3'b000, 8'h00, 8'h00);
      exp_alu(3'b001, 8'h00, 8'h00);
      exp_alu(3'b010, 8'h00, 8'h01);
      exp_we(5'd21, 8'h01);
      exp_alu(3'b000, 8'h00, 8'h00);
      exp_alu(3'b001, 8'h00, 8'h00);
      exp_alu(3'b000, 8'h01, 8'h01);
      exp_alu(3'b001, 8'h01, 8'h01);
      start_prog();
      wait_halt(400, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL skzwrap_halt got halted=%b want 1", halted); end
      n_tests++; if (pc !== 5'd3 || acc !== 8'h01) begin n_fail++; $display("FAIL skzwrap_state got pc=%0d acc=%h want 3 01", pc, acc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL skzwrap_event got none want %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL skzwrap_event got %h want %h", o, e); end end
      end
      n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL skzwrap_extra got %0d events want 0", obs_q.size()); end
   endtask

   // ADD, ADD, STO, STO back to back: EXEC-to-EXEC 6 cycles, STO-to-STO 3 cycles.
   task automatic test_back_to_back;
      bit ok;
      ev_t e, o;
      int  c [4];
      prep();
      init_mem[0]  = ins(ADD, 5'd10);
      init_mem[1]  = ins(ADD, 5'd10);
      init_mem[2]  = ins(STO, 5'd11);
      init_mem[3]  = ins(STO, 5'd12);
      init_mem[4]  = ins(HLT, 5'd0);
      init_mem[10] = 8'h05;
      exp_alu(3'b010, 8'h00, 8'h05);
      exp_alu(3'b010, 8'h05, 8'h05);
      exp_we(5'd11, 8'h0A);
      exp_we(5'd12, 8'h0A);
      start_prog();
      wait_halt(300, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_halt got halted=%b want 1", halted); end
      n_tests++;
      if (obs_cyc.size() != 4) begin
         n_fail++; $display("FAIL b2b_strobe_cycles got %0d want 4", obs_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) c[i] = obs_cyc[i];
         n_tests++; if (c[1] - c[0] != 6) begin n_fail++; $display("FAIL b2b_add_latency got %0d want 6", c[1] - c[0]); end
         n_tests++; if (c[2] - c[1] != 4) begin n_fail++; $display("FAIL b2b_exec_to_sto got %0d want 4", c[2] - c[1]); end
         n_tests++; if (c[3] - c[2] != 3) begin n_fail++; $display("FAIL b2b_sto_latency got %0d want 3", c[3] - c[2]); end
      end
      n_tests++; if (acc !== 8'h0A || pc !== 5'd5) begin n_fail++; $display("FAIL b2b_state got acc=%h pc=%0d want 0a 5", acc, pc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_event got none want %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL b2b_event got %h want %h", o, e); end end
      end
      n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra got %0d events want 0", obs_q.size()); end
   endtask

   // Reset lands during EXEC of an ADD; the ADD must never write back.
   task automatic test_reset_mid;
      bit ok;
      ev_t e, o;
      int  seen;
      prep();
      init_mem[0]  = ins(LDA, 5'd10);
      init_mem[1]  = ins(ADD, 5'd10);
      init_mem[2]  = ins(HLT, 5'd0);
      init_mem[10] = 8'h40;
      exp_alu(3'b000, 8'h40, 8'h40);
      start_prog();
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (bus.alu_en) begin
            seen++;
            if (seen == 2) break;
         end
      end
      n_tests++; if (seen != 2) begin n_fail++; $display("FAIL rmid_reach_exec got %0d alu cycles want 2", seen); end
      n_tests++; if (acc !== 8'h40) begin n_fail++; $display("FAIL rmid_acc_before got %h want 40", acc); end
      rst = 1'b1;
      #1;
      n_tests++; if (acc !== 8'h00 || pc !== PC_RST) begin n_fail++; $display("FAIL rmid_regs got acc=%h pc=%0d want 00 %0d", acc, pc, PC_RST); end
      n_tests++; if (bus.alu_en !== 1'b0 || bus.mem_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_outputs got alu_en=%b mem_we=%b busy=%b want 0 0 0", bus.alu_en, bus.mem_we, busy); end
      @(posedge clk); #1;
      n_tests++; if (acc !== 8'h00) begin n_fail++; $display("FAIL rmid_no_wb got %h want 00", acc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL rmid_event got none want %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL rmid_event got %h want %h", o, e); end end
      end
      n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmid_extra got %0d events want 0", obs_q.size()); end
      exp_alu(3'b000, 8'h40, 8'h40);
      exp_alu(3'b010, 8'h40, 8'h40);
      start_prog();
      wait_halt(300, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rmid_restart_halt got halted=%b want 1", halted); end
      n_tests++; if (acc !== 8'h80 || pc !== 5'd3) begin n_fail++; $display("FAIL rmid_restart got acc=%h pc=%0d want 80 3", acc, pc); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); n_tests++;
         if (obs_q.size() == 0) begin n_fail++; $display("FAIL rmid2_event got none want %h", e); end
         else begin o = obs_q.pop_front(); if (o !== e) begin n_fail++; $display("FAIL rmid2_event got %h want %h", o, e); end end
      end
      n_tests++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rmid2_extra got %0d events want 0", obs_q.size()); end
   endtask

   initial begin
      test_reset();
      test_program();
      test_arith("sub", SUB, 8'h02, 8'h05, 8'hFD);
      test_arith("shl", SHL, 8'h81, 8'h01, 8'h02);
      test_arith("shl8", SHL, 8'h81, 8'h08, 8'h00);
      test_skz(8'h00);
      test_skz(8'h01);
      test_jmp_wrap();
      test_skz_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
